// File: rtl/ex_div_if.sv
// Divider request/result bundle between the EX stage and the iterative divider.
// The divider takes the slave modport.
interface ex_div_if #(
  parameter int DW = 32
);
  logic            start_i;
  logic            signed_i;
  logic            annul_i;
  logic [DW-1:0]   opdata1_i;
  logic [DW-1:0]   opdata2_i;
  logic [2*DW-1:0] result_o;
  logic            ready_o;
  logic            stallreq_o;

  modport master (
    output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/ex_div.sv
// Iterative restoring radix-2 divider: one quotient bit per cycle, signed via
// magnitude division with sign fix-up on the final step.
module ex_div #(
  parameter int DW = 32
) (
  input logic    clk,
  input logic    rst,
  ex_div_if.slave div
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_dvd;
  logic [DW-1:0]   r_dvs;
  logic [DW-1:0]   r_rem;
  logic [DW-1:0]   r_quo;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_ready;
  logic [2*DW-1:0] r_result;

  logic            w_accept;
  logic            w_step;
  logic            w_zero;
  logic            w_last;
  logic            w_ready_next;
  logic [DW-1:0]   w_abs1;
  logic [DW-1:0]   w_abs2;
  logic [DW:0]     w_trial;
  logic [DW:0]     w_diff;
  logic            w_qbit;
  logic [DW-1:0]   w_rem_next;
  logic [DW-1:0]   w_quo_next;
  logic [DW-1:0]   w_quo_fix;
  logic [DW-1:0]   w_rem_fix;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FREE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; annul always returns to FREE and wins over start
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FREE: begin
        if (div.start_i && !div.annul_i) begin
          w_state_next = (div.opdata2_i == '0) ? S_BYZERO : S_ON;
        end else begin
          w_state_next = S_FREE;
        end
      end
      S_BYZERO: w_state_next = div.annul_i ? S_FREE : S_END;
      S_ON: begin
        if (div.annul_i) begin
          w_state_next = S_FREE;
        end else if (r_cnt == LAST) begin
          w_state_next = S_END;
        end else begin
          w_state_next = S_ON;
        end
      end
      S_END: w_state_next = (div.annul_i || !div.start_i) ? S_FREE : S_END;
      default: w_state_next = S_FREE;
    endcase
  end

  // Datapath control decoded from the current state
  always_comb begin
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_zero   = 1'b0;
    case (r_state)
      S_FREE:   w_accept = div.start_i && !div.annul_i;
      S_BYZERO: w_zero   = !div.annul_i;
      S_ON:     w_step   = !div.annul_i;
      S_END:    w_step   = 1'b0;
      default:  w_step   = 1'b0;
    endcase
    w_last       = w_step && (r_cnt == LAST);
    // ready lags END entry by one edge so the result register is already stable
    w_ready_next = (r_state == S_END) && (w_state_next == S_END);
  end

  assign w_abs1 = (div.signed_i && div.opdata1_i[DW-1]) ? ('0 - div.opdata1_i) : div.opdata1_i;
  assign w_abs2 = (div.signed_i && div.opdata2_i[DW-1]) ? ('0 - div.opdata2_i) : div.opdata2_i;

  assign w_trial    = {r_rem, r_dvd[DW-1]};
  assign w_diff     = w_trial - {1'b0, r_dvs};
  assign w_qbit     = ~w_diff[DW];
  assign w_rem_next = w_qbit ? w_diff[DW-1:0] : w_trial[DW-1:0];
  assign w_quo_next = {r_quo[DW-2:0], w_qbit};
  assign w_quo_fix  = r_neg_q ? ('0 - w_quo_next) : w_quo_next;
  assign w_rem_fix  = r_neg_r ? ('0 - w_rem_next) : w_rem_next;

  // Operand latch, shift/subtract iteration and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= '0;
    end else begin
      r_ready <= w_ready_next;
      if (w_accept) begin
        r_cnt   <= '0;
        r_dvd   <= w_abs1;
        r_dvs   <= w_abs2;
        r_rem   <= '0;
        r_quo   <= '0;
        r_neg_q <= div.signed_i && (div.opdata1_i[DW-1] ^ div.opdata2_i[DW-1]);
        r_neg_r <= div.signed_i && div.opdata1_i[DW-1];
      end else if (w_step) begin
        r_cnt <= r_cnt + CW'(1);
        r_dvd <= {r_dvd[DW-2:0], 1'b0};
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
        if (w_last) begin
          r_result <= {w_rem_fix, w_quo_fix};
        end else begin
          r_result <= r_result;
        end
      end else if (w_zero) begin
        r_result <= '0;
      end else begin
        r_result <= r_result;
      end
    end
  end

  assign div.result_o   = r_result;
  assign div.ready_o    = r_ready;
  assign div.stallreq_o = div.start_i & ~r_ready;
endmodule
